// File: rtl/morse_fsm.sv
// Serial Morse decoder: assembles dot/dash symbols into characters and stores up to
// ten ASCII codes, raising done once the buffer is full.
module morse_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] inputSignal,
    output logic [7:0] letter0,
    output logic [7:0] letter1,
    output logic [7:0] letter2,
    output logic [7:0] letter3,
    output logic [7:0] letter4,
    output logic [7:0] letter5,
    output logic [7:0] letter6,
    output logic [7:0] letter7,
    output logic [7:0] letter8,
    output logic [7:0] letter9,
    output logic       done
);

    typedef enum logic [0:0] {StRun, StFull} state_e;

    state_e      state_q, state_d;
    logic [4:0]  pattern_q, pattern_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [3:0]  index_q, index_d;
    logic [7:0]  letters_q [10];
    logic        wr_en;
    logic [7:0]  wr_char;

    // Pattern holds dot=0 / dash=1 with the first symbol in bit cnt-1.
    function automatic logic [7:0] decode(input logic [2:0] cnt, input logic [4:0] pat);
        logic [7:0] ch;
        ch = 8'h3F;
        case (cnt)
            3'd1: ch = pat[0] ? "T" : "E";
            3'd2: begin
                case (pat[1:0])
                    2'b00: ch = "I";
                    2'b01: ch = "A";
                    2'b10: ch = "N";
                    default: ch = "M";
                endcase
            end
            3'd3: begin
                case (pat[2:0])
                    3'b000: ch = "S";
                    3'b001: ch = "U";
                    3'b010: ch = "R";
                    3'b011: ch = "W";
                    3'b100: ch = "D";
                    3'b101: ch = "K";
                    3'b110: ch = "G";
                    default: ch = "O";
                endcase
            end
            3'd4: begin
                case (pat[3:0])
                    4'b0000: ch = "H";
                    4'b0001: ch = "V";
                    4'b0010: ch = "F";
                    4'b0100: ch = "L";
                    4'b0110: ch = "P";
                    4'b0111: ch = "J";
                    4'b1000: ch = "B";
                    4'b1001: ch = "X";
                    4'b1010: ch = "C";
                    4'b1011: ch = "Y";
                    4'b1100: ch = "Z";
                    4'b1101: ch = "Q";
                    default: ch = 8'h3F;
                endcase
            end
            3'd5: begin
                case (pat)
                    5'b01111: ch = "1";
                    5'b00111: ch = "2";
                    5'b00011: ch = "3";
                    5'b00001: ch = "4";
                    5'b00000: ch = "5";
                    5'b10000: ch = "6";
                    5'b11000: ch = "7";
                    5'b11100: ch = "8";
                    5'b11110: ch = "9";
                    5'b11111: ch = "0";
                    default: ch = 8'h3F;
                endcase
            end
            default: ch = 8'h3F;
        endcase
        return ch;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRun;
            pattern_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            index_q   <= '0;
            for (int i = 0; i < 10; i++) letters_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            index_q   <= index_d;
            for (int i = 0; i < 10; i++) begin
                if (wr_en && index_q == 4'(i)) letters_q[i] <= wr_char;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        index_d   = index_q;
        wr_en     = 1'b0;
        wr_char   = 8'h20;
        if (state_q == StRun) begin
            unique case (inputSignal)
                2'b01, 2'b10: begin
                    if (count_q < 3'd5) begin
                        pattern_d = {pattern_q[3:0], inputSignal[1]};
                        count_d   = count_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                2'b11: begin
                    wr_en = 1'b1;
                    if (count_q == 3'd0) wr_char = 8'h20;
                    else if (ovf_q)      wr_char = 8'h3F;
                    else                 wr_char = decode(count_q, pattern_q);
                    index_d   = index_q + 4'd1;
                    pattern_d = '0;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    if (index_q == 4'd9) state_d = StFull;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        done    = (state_q == StFull);
        letter0 = letters_q[0];
        letter1 = letters_q[1];
        letter2 = letters_q[2];
        letter3 = letters_q[3];
        letter4 = letters_q[4];
        letter5 = letters_q[5];
        letter6 = letters_q[6];
        letter7 = letters_q[7];
        letter8 = letters_q[8];
        letter9 = letters_q[9];
    end

endmodule

// File: tb/tb_morse_fsm.sv
// Scoreboard bench for morse_fsm: directed symbol streams push expected buffer snapshots,
// a negedge monitor pops and compares them against the registered outputs.
module tb_morse_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] inputSignal = 2'b00;
    logic [7:0] letter0, letter1, letter2, letter3, letter4;
    logic [7:0] letter5, letter6, letter7, letter8, letter9;
    logic       done;

    morse_fsm dut (
        .clk(clk), .reset(reset), .inputSignal(inputSignal),
        .letter0(letter0), .letter1(letter1), .letter2(letter2), .letter3(letter3),
        .letter4(letter4), .letter5(letter5), .letter6(letter6), .letter7(letter7),
        .letter8(letter8), .letter9(letter9), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        string           name;
        logic [9:0][7:0] l;
        logic            d;
    } exp_t;

    exp_t            sb[$];
    exp_t            e;
    logic [9:0][7:0] exp_l;
    logic            exp_d;
    logic [9:0][7:0] dut_l;
    int              cyc = 0;
    int              last_due = 0;
    int              checks = 0;
    int              failures = 0;

    assign dut_l = {letter9, letter8, letter7, letter6, letter5,
                    letter4, letter3, letter2, letter1, letter0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: snapshot missed, due cycle %0d seen at %0d", e.name, e.due, cyc);
            end else begin
                for (int i = 0; i < 10; i++) begin
                    checks++;
                    if (dut_l[i] !== e.l[i]) begin
                        failures++;
                        $display("FAIL %s letter%0d: got %h expected %h", e.name, i, dut_l[i],
                                 e.l[i]);
                    end
                end
                checks++;
                if (done !== e.d) begin
                    failures++;
                    $display("FAIL %s done: got %b expected %b", e.name, done, e.d);
                end
            end
        end
    end

    task automatic tick(input logic [1:0] s, input logic r);
        @(negedge clk);
        inputSignal = s;
        reset       = r;
        last_due    = cyc + 1;
    endtask

    task automatic chk(input string name);
        exp_t x;
        x.due  = last_due;
        x.name = name;
        x.l    = exp_l;
        x.d    = exp_d;
        sb.push_back(x);
    endtask

    task automatic do_reset(input string name);
        tick(2'b00, 1'b1);
        exp_l = '0;
        exp_d = 1'b0;
        chk(name);
    endtask

    initial begin
        exp_l = '0;
        exp_d = 1'b0;

        // A, S, T
        do_reset("reset0");
        tick(2'b00, 0); tick(2'b01, 0); tick(2'b10, 0); tick(2'b11, 0);
        exp_l[0] = 8'h41; chk("A");
        tick(2'b01, 0); tick(2'b01, 0); tick(2'b01, 0); tick(2'b11, 0);
        exp_l[1] = 8'h53; chk("S");
        tick(2'b10, 0); tick(2'b11, 0);
        exp_l[2] = 8'h54; chk("T");
        do_reset("reset1");

        // Word gap, digit 0, back-to-back gap
        tick(2'b11, 0);
        exp_l[0] = 8'h20; chk("space");
        for (int k = 0; k < 5; k++) tick(2'b10, 0);
        tick(2'b11, 0);
        exp_l[1] = 8'h30; chk("zero");
        tick(2'b11, 0);
        exp_l[2] = 8'h20; chk("space2");
        do_reset("reset2");

        // Overflow, recovery, unlisted 4-symbol code
        for (int k = 0; k < 6; k++) tick(2'b01, 0);
        tick(2'b11, 0);
        exp_l[0] = 8'h3F; chk("overflow");
        tick(2'b01, 0); tick(2'b01, 0); tick(2'b11, 0);
        exp_l[1] = 8'h49; chk("I");
        tick(2'b01, 0); tick(2'b01, 0); tick(2'b10, 0); tick(2'b10, 0); tick(2'b11, 0);
        exp_l[2] = 8'h3F; chk("invalid4");
        do_reset("reset3");

        // Fill buffer with E, then confirm further input is ignored
        for (int k = 0; k < 10; k++) begin
            tick(2'b01, 0); tick(2'b11, 0);
            exp_l[k] = 8'h45;
            if (k == 9) exp_d = 1'b1;
            chk($sformatf("fillE%0d", k));
        end
        tick(2'b10, 0); tick(2'b11, 0);
        chk("full_hold");
        do_reset("reset4");

        // Reset mid-character with letter-end on the same edge
        tick(2'b01, 0); tick(2'b10, 0); tick(2'b11, 1);
        chk("reset_mid");
        tick(2'b01, 0); tick(2'b10, 0); tick(2'b11, 0);
        exp_l[0] = 8'h41; chk("A_after_reset");
        tick(2'b10, 0); tick(2'b10, 0); tick(2'b01, 0); tick(2'b10, 0); tick(2'b11, 0);
        exp_l[1] = 8'h51; chk("Q");
        for (int k = 0; k < 4; k++) tick(2'b10, 0);
        tick(2'b01, 0); tick(2'b11, 0);
        exp_l[2] = 8'h39; chk("nine");
        tick(2'b00, 0); tick(2'b00, 0);
        chk("idle_hold");

        tick(2'b00, 0);
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d snapshots never checked", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
